uart_hex_cmd_parser: RTL and testbench
======================================

# uart_hex_cmd_parser

Consumes bytes from the UART receiver and decodes ASCII hex command lines into single-byte bus reads and writes. It returns a short ASCII reply through the UART transmitter. It sits between the receiver (`ready`/`dataOut`/`readData`) and the transmitter (`newData`/`dataIn`/`done`), and is the debug/host-control path into the design's register space.

## Interface
- `ADDR_NIBBLES`, default 4: hex digits of address; the bus address width is 4*ADDR_NIBBLES.
- `BUS_TIMEOUT`, default 255: cycles to wait for `busAck` before aborting.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rxReady` input 1: receiver has a byte.
- `rxData` input 8: received byte.
- `rxRead` output 1: one-cycle pulse, byte consumed.
- `txDone` input 1: transmitter idle.
- `txNewData` output 1: one-cycle pulse, load `txData`.
- `txData` output 8: byte to transmit.
- `busAddr` output 4*ADDR_NIBBLES: target address.
- `busWData` output 8: write data.
- `busWrite` output 1: write request, level.
- `busRead` output 1: read request, level.
- `busRData` input 8: read data, valid with `busAck`.
- `busAck` input 1: one-cycle completion strobe.

## Operation
- Grammar: `W` + ADDR_NIBBLES hex + 2 hex + EOL → write. `R` + ADDR_NIBBLES hex + EOL → read. EOL is CR (0x0D) or LF (0x0A).
- Command letters and hex digits are case-insensitive. No spaces are allowed.
- States:
  - IDLE: `W`/`w` or `R`/`r` → ADDR. CR/LF ignored. Anything else → DISCARD.
  - ADDR: shift each nibble in MSB-first; after the last nibble go to DATA (write) or EOL (read).
  - DATA: 2 nibbles, MSB first → EOL.
  - EOL: CR/LF → BUS. Any other byte → DISCARD.
  - BUS: assert `busWrite` or `busRead` until `busAck` or timeout → REPLY.
  - REPLY: send the reply bytes → IDLE.
  - DISCARD: drop bytes until CR/LF, then REPLY with error.
- Invalid hex digit in ADDR or DATA → DISCARD.
- Replies:
  - Write: `K`, LF.
  - Read: two uppercase hex digits of `busRData`, then LF.
  - Parse error: `?`, LF.
  - Bus timeout: `!`, LF.
- `busRData` is latched on `busAck`.
- Bytes arriving during BUS or REPLY are not consumed (`rxRead` stays low). The receiver holds them.
- CR then LF: the LF is ignored in IDLE.

## Timing
- Reset values: `rxRead`=0, `txNewData`=0, `txData`=0, `busAddr`=0, `busWData`=0, `busWrite`=0, `busRead`=0, state=IDLE, timeout counter=0.
- Consume: `rxRead` is registered. It pulses in the cycle after `rxReady` is sampled high with `rxRead` low. A byte is never consumed twice.
- Transmit: `txNewData` pulses for one cycle when `txDone`=1. `txData` is valid in the same cycle.
  - Hold-off: after a pulse, `txDone` is ignored for 2 cycles, because the transmitter's `done` falls one cycle late.
- Bus: `busAddr` and `busWData` are stable from request assertion through ack.
  - The request deasserts in the cycle after `busAck`.
  - `busAck` in the same cycle as the request asserts is accepted.
  - Timeout: the counter reaches BUS_TIMEOUT with no ack → drop the request and reply `!`.
- Latency: the request asserts 1 cycle after the EOL byte is consumed.
- `rst` mid-operation: the partial command is lost and all outputs return to reset values immediately. A byte already in the transmitter completes on its own.

## Configuration
- `HEX_CMD_ECHO_EN` defined:
  - Every consumed byte is echoed to the transmitter before it is processed.
  - The next byte is not consumed until the echo has been handed to the transmitter.
  - Replies follow the echo of the EOL byte.
- Not defined: no echo; the transmitter carries only replies.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state enum;
  - ASCII constants (`W`, `R`, `K`, `?`, `!`, CR, LF);
  - a `nibble2char` function (0-15 → `0`-`9`, `A`-`F`).
- Hex decode reuses the existing Char2Hex module combinationally on `rxData`.
- One sub-module, `uart_reply_seq`: a byte-queue sequencer of up to 3 bytes. It owns `txNewData`/`txData`, the hold-off handshake, and the echo path.

## Test plan
- `W12AB5A\r` → one `busWrite` with `busAddr`=0x12AB and `busWData`=0x5A; ack after 3 cycles → TX `K`,0x0A.
- `r00ff\n`, with `busAck` and `busRData`=0x3C → one `busRead` at 0x00FF; TX `3`,`C`,0x0A.
- `W12G4\n` → no bus access; TX `?`,0x0A; the following `R0001\n` is handled normally.
- `R0010\r` with no ack → `busRead` high for exactly BUS_TIMEOUT cycles, then TX `!`,0x0A.
- `R0001\r\n` with `rxReady` held high back-to-back → each byte gets exactly one `rxRead`; the LF produces no reply.
- `rst` asserted during ADDR after `W12` → outputs at reset values; a subsequent `W0000FF\n` writes 0xFF to 0x0000. With `HEX_CMD_ECHO_EN`, TX shows all 8 echoed bytes, then `K`,0x0A.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and helpers for the UART hex command parser.
// Optional echo feature is selected with the HEX_CMD_ECHO_EN macro in uart_hex_cmd_parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EOL,
    ST_BUS,
    ST_REPLY,
    ST_DISCARD
  } state_e;

  typedef enum logic [1:0] {
    RPL_OK,
    RPL_READ,
    RPL_ERR,
    RPL_TMO
  } reply_e;

  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_W_LC = 8'h77;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_R_LC = 8'h72;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_QM   = 8'h3F;
  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  // 0-15 to uppercase ASCII hex digit
  function automatic logic [7:0] nibble2char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // CR or LF terminates a command line
  function automatic logic is_eol(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/Char2Hex.sv
// Combinational ASCII hex digit decoder ('0'-'9', 'A'-'F', 'a'-'f').
module Char2Hex (
  input  logic [7:0] charIn,
  output logic [3:0] hexOut,
  output logic       isHex
);

  // Map the character to its nibble value and flag valid digits
  always_comb begin
    hexOut = 4'h0;
    isHex  = 1'b0;
    if (charIn >= 8'h30 && charIn <= 8'h39) begin
      hexOut = 4'(charIn - 8'h30);
      isHex  = 1'b1;
    end else if (charIn >= 8'h41 && charIn <= 8'h46) begin
      hexOut = 4'(charIn - 8'h37);
      isHex  = 1'b1;
    end else if (charIn >= 8'h61 && charIn <= 8'h66) begin
      hexOut = 4'(charIn - 8'h57);
      isHex  = 1'b1;
    end
  end

endmodule

// File: rtl/uart_reply_seq.sv
// Up-to-3-byte transmit queue: owns txNewData/txData, the post-pulse hold-off
// on txDone and the single-byte echo path (used when HEX_CMD_ECHO_EN is defined).
module uart_reply_seq
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_len,
  input  logic [7:0] load_b0,
  input  logic [7:0] load_b1,
  input  logic [7:0] load_b2,
  input  logic       echo,
  input  logic [7:0] echo_data,
  input  logic       txDone,
  output logic       txNewData,
  output logic [7:0] txData,
  output logic       busy_c
);

  logic [7:0] q0, q1, q2;
  logic [1:0] count;
  logic [1:0] hold;

  assign busy_c = (count != 2'd0);

  // Queue fill (only while empty) and paced hand-off to the transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0        <= 8'h00;
      q1        <= 8'h00;
      q2        <= 8'h00;
      count     <= 2'd0;
      hold      <= 2'd0;
      txNewData <= 1'b0;
      txData    <= 8'h00;
    end else begin
      txNewData <= 1'b0;
      if (hold != 2'd0) hold <= hold - 2'd1;
      if (load) begin
        q0    <= load_b0;
        q1    <= load_b1;
        q2    <= load_b2;
        count <= load_len;
      end else if (echo) begin
        q0    <= echo_data;
        count <= 2'd1;
      end else if (count != 2'd0 && txDone && hold == 2'd0) begin
        // done drops one cycle late, so ignore it for two cycles after a pulse
        txNewData <= 1'b1;
        txData    <= q0;
        q0        <= q1;
        q1        <= q2;
        count     <= count - 2'd1;
        hold      <= 2'd2;
      end
    end
  end

endmodule

// File: rtl/uart_hex_cmd_parser.sv
// ASCII hex command parser: "W<addr><data>EOL" writes, "R<addr>EOL" reads,
// replies K / hex byte / ? / ! followed by LF.
// Define HEX_CMD_ECHO_EN to echo every consumed byte before it is processed.
module uart_hex_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_NIBBLES = 4,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxReady,
  input  logic [7:0]                rxData,
  output logic                      rxRead,
  input  logic                      txDone,
  output logic                      txNewData,
  output logic [7:0]                txData,
  output logic [4*ADDR_NIBBLES-1:0] busAddr,
  output logic [7:0]                busWData,
  output logic                      busWrite,
  output logic                      busRead,
  input  logic [7:0]                busRData,
  input  logic                      busAck
);

  localparam int unsigned AW = 4 * ADDR_NIBBLES;
  localparam int unsigned NW = $clog2(ADDR_NIBBLES + 1);
  localparam int unsigned TW = $clog2(BUS_TIMEOUT + 1);

  state_e        state;
  reply_e        reply;
  logic          is_write;
  logic          reply_loaded;
  logic [NW-1:0] nib_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rdata;
  logic [3:0]    nib;
  logic          nib_ok;
  logic          seq_busy_c;
  logic          consume_c;
  logic          echo_c;
  logic          load_c;
  logic [1:0]    load_len_c;
  logic [7:0]    b0_c, b1_c, b2_c;

  Char2Hex u_hex (
    .charIn (rxData),
    .hexOut (nib),
    .isHex  (nib_ok)
  );

  uart_reply_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_len  (load_len_c),
    .load_b0   (b0_c),
    .load_b1   (b1_c),
    .load_b2   (b2_c),
    .echo      (echo_c),
    .echo_data (rxData),
    .txDone    (txDone),
    .txNewData (txNewData),
    .txData    (txData),
    .busy_c    (seq_busy_c)
  );

  // Byte acceptance: parsing states only, never twice for the same byte
  always_comb begin
    consume_c = rxReady && !rxRead &&
                (state == ST_IDLE || state == ST_ADDR || state == ST_DATA ||
                 state == ST_EOL  || state == ST_DISCARD);
`ifdef HEX_CMD_ECHO_EN
    consume_c = consume_c && !seq_busy_c;
    echo_c    = consume_c;
`else
    echo_c    = 1'b0;
`endif
    load_c = (state == ST_REPLY) && !reply_loaded && !seq_busy_c;
  end

  // Reply byte selection
  always_comb begin
    load_len_c = 2'd2;
    b0_c       = CH_BANG;
    b1_c       = CH_LF;
    b2_c       = CH_LF;
    unique case (reply)
      RPL_OK:  b0_c = CH_K;
      RPL_ERR: b0_c = CH_QM;
      RPL_READ: begin
        load_len_c = 2'd3;
        b0_c       = nibble2char(rdata[7:4]);
        b1_c       = nibble2char(rdata[3:0]);
      end
      default: b0_c = CH_BANG;
    endcase
  end

  // Command FSM, bus handshake and timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      reply        <= RPL_OK;
      rxRead       <= 1'b0;
      busAddr      <= '0;
      busWData     <= 8'h00;
      busWrite     <= 1'b0;
      busRead      <= 1'b0;
      is_write     <= 1'b0;
      reply_loaded <= 1'b0;
      nib_cnt      <= '0;
      tmo_cnt      <= '0;
      rdata        <= 8'h00;
    end else begin
      rxRead <= consume_c;
      unique case (state)
        ST_IDLE: if (consume_c) begin
          nib_cnt <= '0;
          if (rxData == CH_W || rxData == CH_W_LC) begin
            is_write <= 1'b1;
            state    <= ST_ADDR;
          end else if (rxData == CH_R || rxData == CH_R_LC) begin
            is_write <= 1'b0;
            state    <= ST_ADDR;
          end else if (!is_eol(rxData)) begin
            state <= ST_DISCARD;
          end
        end
        ST_ADDR, ST_DATA: if (consume_c) begin
          if (nib_ok) begin
            if (state == ST_ADDR) busAddr <= AW'({busAddr, nib});
            else                  busWData <= {busWData[3:0], nib};
            if ((state == ST_ADDR && nib_cnt == NW'(ADDR_NIBBLES - 1)) ||
                (state == ST_DATA && nib_cnt == NW'(1))) begin
              nib_cnt <= '0;
              state   <= (state == ST_ADDR && is_write) ? ST_DATA : ST_EOL;
            end else begin
              nib_cnt <= nib_cnt + NW'(1);
            end
          end else if (is_eol(rxData)) begin
            // a truncated line already ended; nothing left to discard
            reply <= RPL_ERR;
            state <= ST_REPLY;
          end else begin
            state <= ST_DISCARD;
          end
        end
        ST_EOL: if (consume_c) begin
          state <= is_eol(rxData) ? ST_BUS : ST_DISCARD;
        end
        ST_BUS: begin
          if (!busWrite && !busRead) begin
            busWrite <= is_write;
            busRead  <= !is_write;
            tmo_cnt  <= '0;
          end else if (busAck) begin
            busWrite <= 1'b0;
            busRead  <= 1'b0;
            rdata    <= busRData;
            reply    <= is_write ? RPL_OK : RPL_READ;
            state    <= ST_REPLY;
          end else if (tmo_cnt == TW'(BUS_TIMEOUT - 1)) begin
            busWrite <= 1'b0;
            busRead  <= 1'b0;
            tmo_cnt  <= '0;
            reply    <= RPL_TMO;
            state    <= ST_REPLY;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_REPLY: begin
          if (load_c) begin
            reply_loaded <= 1'b1;
          end else if (reply_loaded && !seq_busy_c) begin
            reply_loaded <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_DISCARD: if (consume_c && is_eol(rxData)) begin
          reply <= RPL_ERR;
          state <= ST_REPLY;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Directed bench for uart_hex_cmd_parser with receiver, transmitter and bus models.
// Expected TX streams include echoed command bytes when HEX_CMD_ECHO_EN is defined.
module tb_uart_hex_cmd_parser;

`ifdef HEX_CMD_ECHO_EN
  localparam bit ECHO_ON = 1'b1;
`else
  localparam bit ECHO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxReady = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxRead;
  logic        txDone = 1'b1;
  logic        txNewData;
  logic [7:0]  txData;
  logic [15:0] busAddr;
  logic [7:0]  busWData;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busRData = 8'hEE;
  logic        busAck = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  uart_hex_cmd_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rxReady   (rxReady),
    .rxData    (rxData),
    .rxRead    (rxRead),
    .txDone    (txDone),
    .txNewData (txNewData),
    .txData    (txData),
    .busAddr   (busAddr),
    .busWData  (busWData),
    .busWrite  (busWrite),
    .busRead   (busRead),
    .busRData  (busRData),
    .busAck    (busAck)
  );

  always #5 clk = ~clk;

  // Receiver model: present queued bytes, pop one per rxRead pulse
  logic [7:0] rx_q[$];
  int rx_reads = 0;
  int rx_under = 0;
  always @(negedge clk) begin
    if (rxRead) begin
      rx_reads++;
      if (rx_q.size() == 0) rx_under++;
      else void'(rx_q.pop_front());
    end
    rxReady = (rx_q.size() != 0);
    rxData  = rxReady ? rx_q[0] : 8'h00;
  end

  // Transmitter model: done falls one cycle after a load, busy for a few cycles
  logic [7:0] tx_log[$];
  int  tx_busy = 0;
  bit  tx_pend = 1'b0;
  int  tx_viol = 0;
  always @(negedge clk) begin
    if (tx_busy > 0) begin
      tx_busy--;
      if (tx_busy == 0) txDone = 1'b1;
    end
    if (tx_pend) begin
      tx_pend = 1'b0;
      txDone  = 1'b0;
      tx_busy = 3;
    end
    if (txNewData) begin
      if (!txDone) tx_viol++;
      tx_log.push_back(txData);
      tx_pend = 1'b1;
    end
  end

  // Bus slave model: ack after ack_delay request cycles (0 = never)
  int bus_n = 0;
  int hi_cnt = 0;
  int last_hi = 0;
  int ack_delay = 1;
  int stab_viol = 0;
  logic [7:0]  rdata_val = 8'h00;
  logic [15:0] last_addr = 16'h0;
  logic [7:0]  last_wdata = 8'h0;
  logic        last_write = 1'b0;
  always @(negedge clk) begin
    busAck   = 1'b0;
    busRData = 8'hEE;
    if (busWrite || busRead) begin
      if (hi_cnt == 0) begin
        bus_n++;
        last_addr  = busAddr;
        last_wdata = busWData;
        last_write = busWrite;
      end else if (busAddr != last_addr || busWData != last_wdata) begin
        stab_viol++;
      end
      if (busWrite && busRead) stab_viol++;
      hi_cnt++;
      last_hi = hi_cnt;
      if (hi_cnt == ack_delay) begin
        busAck   = 1'b1;
        busRData = rdata_val;
      end
    end else begin
      hi_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic string ec(input string s);
    return ECHO_ON ? s : "";
  endfunction

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic chk_tx(input string tag, input string exp);
    logic [7:0] got;
    wait_tx(exp.len(), 2000);
    chk({tag, "_txlen"}, 32'(tx_log.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hFF;
      chk($sformatf("%s_tx%0d", tag, i), {24'h0, got}, {24'h0, exp[i]});
    end
    tx_log.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rxRead"}, {31'h0, rxRead}, 32'h0);
    chk({tag, "_txNewData"}, {31'h0, txNewData}, 32'h0);
    chk({tag, "_txData"}, {24'h0, txData}, 32'h0);
    chk({tag, "_busAddr"}, {16'h0, busAddr}, 32'h0);
    chk({tag, "_busWData"}, {24'h0, busWData}, 32'h0);
    chk({tag, "_busWrite"}, {31'h0, busWrite}, 32'h0);
    chk({tag, "_busRead"}, {31'h0, busRead}, 32'h0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("post_rst");

    // Write with ack after 3 cycles
    bus_n = 0; ack_delay = 3;
    send("W12AB5A\015");
    chk_tx("wr", {ec("W12AB5A\015"), "K\n"});
    chk("wr_count", 32'(bus_n), 32'd1);
    chk("wr_kind", {31'h0, last_write}, 32'd1);
    chk("wr_addr", {16'h0, last_addr}, 32'h12AB);
    chk("wr_data", {24'h0, last_wdata}, 32'h5A);
    chk("wr_hi", 32'(last_hi), 32'd3);

    // Lowercase read, ack in the first request cycle
    bus_n = 0; ack_delay = 1; rdata_val = 8'h3C;
    send("r00ff\n");
    chk_tx("rd", {ec("r00ff\n"), "3C\n"});
    chk("rd_count", 32'(bus_n), 32'd1);
    chk("rd_kind", {31'h0, last_write}, 32'd0);
    chk("rd_addr", {16'h0, last_addr}, 32'h00FF);
    chk("rd_hi", 32'(last_hi), 32'd1);

    // Bad hex digit, then a normal read queued behind it
    bus_n = 0; ack_delay = 2; rdata_val = 8'hA5;
    send("W12G4\nR0001\n");
    chk_tx("err", {ec("W12G4\n"), "?\n", ec("R0001\n"), "A5\n"});
    chk("err_count", 32'(bus_n), 32'd1);
    chk("err_kind", {31'h0, last_write}, 32'd0);
    chk("err_addr", {16'h0, last_addr}, 32'h0001);

    // Read with no ack: request held for exactly BUS_TIMEOUT cycles
    bus_n = 0; ack_delay = 0;
    send("R0010\015");
    chk_tx("tmo", {ec("R0010\015"), "!\n"});
    chk("tmo_count", 32'(bus_n), 32'd1);
    chk("tmo_addr", {16'h0, last_addr}, 32'h0010);
    chk("tmo_hi", 32'(last_hi), 32'd255);

    // CR LF back-to-back: one read per byte, LF gives no reply
    bus_n = 0; ack_delay = 1; rdata_val = 8'h5A; rx_reads = 0;
    send("R0001\015\n");
    chk_tx("crlf", {ec("R0001\015\n"), "5A\n"});
    chk("crlf_reads", 32'(rx_reads), 32'd7);
    chk("crlf_count", 32'(bus_n), 32'd1);
    chk("crlf_rxq", 32'(rx_q.size()), 32'd0);

    // Reset in the middle of an address, then a clean write
    send("W12");
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    tx_log.delete();
    bus_n = 0; ack_delay = 2;
    send("W0000FF\n");
    chk_tx("wr2", {ec("W0000FF\n"), "K\n"});
    chk("wr2_count", 32'(bus_n), 32'd1);
    chk("wr2_kind", {31'h0, last_write}, 32'd1);
    chk("wr2_addr", {16'h0, last_addr}, 32'h0000);
    chk("wr2_data", {24'h0, last_wdata}, 32'hFF);

    // Protocol integrity across the run
    chk("tx_handshake", 32'(tx_viol), 32'd0);
    chk("bus_stable", 32'(stab_viol), 32'd0);
    chk("rx_underflow", 32'(rx_under), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
